// File: rtl/ir_nec_decoder.sv
// rtl/ir_nec_decoder.sv - NEC infrared frame decoder on a 62.5 us tick
// Measures mark/space widths between edges of the synchronized burst signal.
`timescale 1ns/1ps
module ir_nec_decoder #(
  parameter int TIMEOUT = 200
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        ir_in,
  output logic [15:0] addr_out,
  output logic [7:0]  cmd_out,
  output logic        valid,
  output logic        repeat_pulse,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REP_MARK
  } state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  logic        sync1, sync2, mark_d;
  logic        mark, mark_edge, timeout;
  logic [7:0]  width;
  state_t      state;
  logic [4:0]  bit_cnt;
  logic [31:0] shreg, next_shreg;
  logic        have_frame;
  logic        is_zero, is_one;

  function automatic logic in_rng(input logic [7:0] w, input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  assign mark       = ~sync2;
  assign mark_edge  = mark ^ mark_d;
  assign timeout    = (width == TIMEOUT_W) && !mark_edge;
  assign is_zero    = in_rng(width, 8'd6, 8'd12);
  assign is_one     = in_rng(width, 8'd22, 8'd32);
  assign next_shreg = {is_one, shreg[31:1]};

  // Width counter restarts on every edge so its value at the next edge is the
  // length of the level that just ended.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      mark_d <= 1'b0;
      width  <= 8'd0;
    end else begin
      sync1  <= ir_in;
      sync2  <= sync1;
      mark_d <= mark;
      if (mark_edge)
        width <= 8'd1;
      else if (width != 8'hFF)
        width <= width + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= 5'd0;
      shreg        <= 32'd0;
      have_frame   <= 1'b0;
      addr_out     <= 16'd0;
      cmd_out      <= 8'd0;
      valid        <= 1'b0;
      repeat_pulse <= 1'b0;
      error        <= 1'b0;
    end else begin
      valid        <= 1'b0;
      repeat_pulse <= 1'b0;
      error        <= 1'b0;
      if (state != IDLE && timeout) begin
        error <= 1'b1;
        state <= IDLE;
      end else if (mark_edge) begin
        case (state)
          IDLE: if (mark) state <= LEAD_MARK;
          LEAD_MARK: begin
            if (in_rng(width, 8'd128, 8'd160)) begin
              state <= LEAD_SPACE;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
          LEAD_SPACE: begin
            if (in_rng(width, 8'd64, 8'd80)) begin
              state   <= BIT_MARK;
              bit_cnt <= 5'd0;
            end else if (in_rng(width, 8'd28, 8'd44)) begin
              state <= REP_MARK;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
          BIT_MARK: begin
            if (in_rng(width, 8'd6, 8'd12)) begin
              state <= BIT_SPACE;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
          BIT_SPACE: begin
            if (is_zero || is_one) begin
              shreg <= next_shreg;
              if (bit_cnt == 5'd31) begin
                // The stop burst's rising edge lands here, so it cannot open a frame.
                state <= IDLE;
                if (next_shreg[31:24] == ~next_shreg[23:16]) begin
                  valid      <= 1'b1;
                  addr_out   <= next_shreg[15:0];
                  cmd_out    <= next_shreg[23:16];
                  have_frame <= 1'b1;
                end else begin
                  error <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                state   <= BIT_MARK;
              end
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
          REP_MARK: begin
            if (in_rng(width, 8'd6, 8'd12) && have_frame)
              repeat_pulse <= 1'b1;
            else
              error <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb/tb_ir_nec_decoder.sv - directed bench for ir_nec_decoder
`timescale 1ns/1ps
module tb_ir_nec_decoder;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic        ir_in  = 1'b1;
  logic [15:0] addr_out;
  logic [7:0]  cmd_out;
  logic        valid, repeat_pulse, error;

  int checks = 0, errors = 0;
  int n_valid = 0, n_rep = 0, n_err = 0, n_multi = 0;
  int cyc = 0, err_cyc = -1, t0 = 0;
  int sv_valid, sv_rep, sv_err;

  ir_nec_decoder #(.TIMEOUT(200)) dut (
    .clk_in(clk_in), .reset(reset), .ir_in(ir_in),
    .addr_out(addr_out), .cmd_out(cmd_out),
    .valid(valid), .repeat_pulse(repeat_pulse), .error(error)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (valid) n_valid++;
    if (repeat_pulse) n_rep++;
    if (error) begin
      n_err++;
      err_cyc = cyc;
    end
    if (int'(valid) + int'(repeat_pulse) + int'(error) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic level(input logic lv, input int n);
    ir_in = lv;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      level(1'b0, 9);
      level(1'b1, d[i] ? 27 : 9);
    end
  endtask

  task automatic send_frame(input logic [31:0] d);
    level(1'b0, 144);
    level(1'b1, 72);
    send_bits(d, 32);
    level(1'b0, 9);
    level(1'b1, 30);
  endtask

  task automatic send_repeat();
    level(1'b0, 144);
    level(1'b1, 36);
    level(1'b0, 9);
    level(1'b1, 30);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_addr", 32'(addr_out), 32'h0);
    check("rst_cmd", 32'(cmd_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_repeat", 32'(repeat_pulse), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    reset = 1'b1;
    level(1'b1, 10);

    send_repeat();
    check("rep_no_frame_err", 32'(n_err), 32'd1);
    check("rep_no_frame_rep", 32'(n_rep), 32'd0);

    send_frame(32'hBA45FF00);
    check("f1_valid", 32'(n_valid), 32'd1);
    check("f1_err", 32'(n_err), 32'd1);
    check("f1_addr", 32'(addr_out), 32'hFF00);
    check("f1_cmd", 32'(cmd_out), 32'h45);

    send_frame(32'hBB45FF00);
    check("bad_err", 32'(n_err), 32'd2);
    check("bad_valid", 32'(n_valid), 32'd1);
    check("bad_addr", 32'(addr_out), 32'hFF00);
    check("bad_cmd", 32'(cmd_out), 32'h45);

    send_repeat();
    check("rep_pulse", 32'(n_rep), 32'd1);
    check("rep_err", 32'(n_err), 32'd2);
    check("rep_addr", 32'(addr_out), 32'hFF00);

    level(1'b0, 100);
    level(1'b1, 50);
    check("lead100_err", 32'(n_err), 32'd3);
    level(1'b0, 170);
    level(1'b1, 50);
    check("lead170_err", 32'(n_err), 32'd4);
    send_frame(32'hA55A3412);
    check("f2_valid", 32'(n_valid), 32'd2);
    check("f2_addr", 32'(addr_out), 32'h3412);
    check("f2_cmd", 32'(cmd_out), 32'h5A);

    level(1'b0, 144);
    level(1'b1, 72);
    send_bits(32'hBA45FF00, 9);
    level(1'b0, 9);
    t0 = cyc;
    level(1'b1, 250);
    check("to_err", 32'(n_err), 32'd5);
    check("to_tick", 32'(err_cyc - t0), 32'd203);
    check("to_addr", 32'(addr_out), 32'h3412);
    send_frame(32'hBA45FF00);
    check("f3_valid", 32'(n_valid), 32'd3);
    check("f3_addr", 32'(addr_out), 32'hFF00);

    sv_valid = n_valid;
    sv_rep   = n_rep;
    sv_err   = n_err;
    level(1'b0, 144);
    level(1'b1, 72);
    send_bits(32'h7E81CDAB, 19);
    level(1'b0, 5);
    reset = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("mid_rst_addr", 32'(addr_out), 32'h0);
    check("mid_rst_cmd", 32'(cmd_out), 32'h0);
    ir_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b1;
    level(1'b1, 20);
    check("mid_rst_pulses", 32'((n_valid - sv_valid) + (n_rep - sv_rep) + (n_err - sv_err)), 32'd0);
    send_frame(32'h7E81CDAB);
    check("f4_valid", 32'(n_valid), 32'(sv_valid + 1));
    check("f4_addr", 32'(addr_out), 32'hCDAB);
    check("f4_cmd", 32'(cmd_out), 32'h81);
    check("f4_err", 32'(n_err), 32'(sv_err));

    check("exclusive", 32'(n_multi), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_nec_decoder.md
IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200, meaning the idle-level width in ticks that aborts a frame in progress.
REQ-002 SHALL have port clk_in  input  1  the 16 kHz decoder clock (62.5 us tick) produced by clock_counter.slow_clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ir_in  input  1  raw IR receiver output, active-low (0 = carrier burst), asynchronous to clk_in.
REQ-005 SHALL have port addr_out  output  16  last valid frame address, {byte1, byte0}.
REQ-006 SHALL have port cmd_out  output  8  last valid frame command byte.
REQ-007 SHALL have port valid  output  1  one-cycle pulse on each new valid frame.
REQ-008 SHALL have port repeat_pulse  output  1  one-cycle pulse on each valid NEC repeat code.
REQ-009 SHALL have port error  output  1  one-cycle pulse on any malformed frame or timeout.

Function
REQ-010 SHALL pass ir_in through a 2-flop synchronizer and invert it to mark (1 = burst); all timing SHALL use the synchronized mark.
REQ-011 SHALL run an 8-bit width counter that restarts at 1 on every mark edge, increments each tick, and saturates at 255; "width" means the counter value at the terminating edge.
REQ-012 SHALL use states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REP_MARK.
REQ-013 IDLE: SHALL enter LEAD_MARK on a mark rising edge; all other edges are ignored.
REQ-014 LEAD_MARK: at mark end, width 128..160 -> LEAD_SPACE; otherwise error, IDLE.
REQ-015 LEAD_SPACE: at space end, width 64..80 -> BIT_MARK with bit count 0; 28..44 -> REP_MARK; otherwise error, IDLE.
REQ-016 BIT_MARK: at mark end, width 6..12 -> BIT_SPACE; otherwise error, IDLE.
REQ-017 BIT_SPACE: at space end, width 6..12 shifts in 0, 22..32 shifts in 1, otherwise error, IDLE; bits SHALL be received LSB-first into a 32-bit shift register.
REQ-018 After the 32nd bit, SHALL return to IDLE; the trailing stop burst SHALL NOT start a new frame because it begins in a non-IDLE state and ends in IDLE.
REQ-019 Frame check: byte3 SHALL equal bitwise NOT of byte2; address bytes are unchecked (extended NEC).
REQ-020 Pass: the cycle after the edge that ends the 32nd bit, addr_out and cmd_out SHALL update and valid SHALL pulse for one cycle; fail: error pulses and outputs hold.
REQ-021 REP_MARK: at mark end, width 6..12 with at least one valid frame since reset -> repeat_pulse for one cycle, IDLE; otherwise error, IDLE.
REQ-022 In any non-IDLE state, when the counter reaches TIMEOUT without an edge, SHALL pulse error once and go IDLE.
REQ-023 valid, repeat_pulse, and error SHALL be registered and mutually exclusive in any cycle.
REQ-024 addr_out and cmd_out SHALL hold their values across errors, repeats, and timeouts until the next valid frame.

Reset
REQ-025 When reset is low, SHALL asynchronously clear state to IDLE and clear the synchronizer (to the idle level), the counter, the shift register, addr_out, cmd_out, valid, repeat_pulse, error, and the valid-frame flag.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse on any output; decoding SHALL resume with the next leader after release.

Verification
REQ-027 Frame addr 0x00/0xFF, cmd 0x45/0xBA at nominal widths (144, 72, 9/9, 9/27 ticks) -> one valid pulse; addr_out=0xFF00, cmd_out=0x45.
REQ-028 Same frame with byte3=0xBB -> error pulse, no valid; addr_out and cmd_out keep their prior values.
REQ-029 Valid frame, then repeat code (144 mark, 36 space, 9 mark) -> repeat_pulse once; repeat code sent right after reset -> error only.
REQ-030 Leader mark of 100 ticks -> error; a second leader mark of 170 ticks -> error; state returns to IDLE both times.
REQ-031 ir_in held high for 250 ticks after the 10th bit -> exactly one error pulse at tick 200; the next correct frame decodes.
REQ-032 Reset pulsed low during bit 20 -> all outputs 0, no pulse; the following nominal frame produces valid.
